// File: rtl/key_debounce_pkg.sv
// Shared types for the key debouncer: per-channel FSM state and counter width helper.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_e;

  // Bits needed to hold values 0..max_cnt.
  function automatic int cnt_width(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, press/release FSM, registered pulses.
// Long-press detection is compiled in with KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  , parameter int LONG_CYCLES   = 64
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int CW = cnt_width(LONG_CYCLES);
`else
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
`endif
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic          pressed_s;

  assign pressed_s = ~sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Counter only advances while below DB_LAST, so it saturates by construction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pressed_s) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PRESSED: begin
        if (!pressed_s) begin
          state_d = ST_REL_CHK;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ST_REL_CHK: begin
        if (pressed_s) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q >= DB_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Level follows the settled FSM state; pulses are its edges, so press and
  // release of one channel are mutually exclusive.
  always_comb begin
    level_d = (state_q == ST_PRESSED) || (state_q == ST_REL_CHK);
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = rel_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CW-1:0] HOLD_MAX = CW'(LONG_CYCLES);

  logic [CW-1:0] hold_q, hold_d;
  logic          done_q, done_d;
  logic          long_q, long_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      done_q <= 1'b0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      done_q <= done_d;
      long_q <= long_d;
    end
  end

  // Hold count survives release bounces (REL_CHK) and only clears back in IDLE.
  always_comb begin
    hold_d = hold_q;
    long_d = (hold_q == HOLD_MAX) && !done_q;
    done_d = done_q | long_d;
    if (state_d == ST_IDLE) begin
      hold_d = '0;
      done_d = 1'b0;
    end else if (state_q == ST_PRESSED && hold_q < HOLD_MAX) begin
      hold_d = hold_q + CNT_ONE;
    end
  end

  assign key_long = long_q;
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// N_KEYS independent key debouncers with press/release/long-press pulses.
// Long-press detection is enabled by defining KEY_DEBOUNCE_LONG_PRESS_EN.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  generate
    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_params
      $error("key_debounce: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
    end
  endgenerate

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
      , .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .key_long    (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Random + directed bench for key_debounce against a run-length reference model.
module tb_key_debounce;
  localparam int N = 4;
  localparam int D = 16;
  localparam int L = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key = '1;
  logic [N-1:0] key_level, key_press, key_release, key_long;

  int n_chk = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .key_level(key_level), .key_press(key_press),
    .key_release(key_release), .key_long(key_long)
  );

  always #5 clk = ~clk;

  // Reference: each channel has an accepted state; it flips once D consecutive
  // synchronized samples disagree with it. Outputs show the flip one edge later.
  logic [N-1:0] m_s1, m_s2, m_acc, m_level, m_press, m_rel, m_long, m_done;
  int m_run [N];
  int m_hold[N];

  function automatic logic flips(input logic s2, input logic acc, input int run);
    return ((~s2) != acc) && (run + 1 >= D);
  endfunction

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic LONG_ON = 1'b1;
`else
  localparam logic LONG_ON = 1'b0;
`endif

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n) begin
        m_s1[i] <= 1'b1; m_s2[i] <= 1'b1; m_acc[i] <= 1'b0;
        m_run[i] <= 0; m_hold[i] <= 0; m_done[i] <= 1'b0;
        m_level[i] <= 1'b0; m_press[i] <= 1'b0; m_rel[i] <= 1'b0; m_long[i] <= 1'b0;
      end else begin
        m_s1[i]    <= key[i];
        m_s2[i]    <= m_s1[i];
        m_acc[i]   <= m_acc[i] ^ flips(m_s2[i], m_acc[i], m_run[i]);
        m_run[i]   <= (((~m_s2[i]) != m_acc[i]) && !flips(m_s2[i], m_acc[i], m_run[i]))
                      ? m_run[i] + 1 : 0;
        m_level[i] <= m_acc[i];
        m_press[i] <= m_acc[i] & ~m_level[i];
        m_rel[i]   <= ~m_acc[i] & m_level[i];
        m_hold[i]  <= !(m_acc[i] ^ flips(m_s2[i], m_acc[i], m_run[i])) ? 0 :
                      (m_acc[i] && m_run[i] == 0 && m_hold[i] < L) ? m_hold[i] + 1 : m_hold[i];
        m_long[i]  <= LONG_ON && (m_hold[i] == L) && !m_done[i];
        m_done[i]  <= !(m_acc[i] ^ flips(m_s2[i], m_acc[i], m_run[i])) ? 1'b0 :
                      (m_done[i] | (LONG_ON && (m_hold[i] == L)));
      end
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  int rem[N];
  int cnt, at, cnt2, at2;

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          chk("level", key_level, m_level);
          chk("press", key_press, m_press);
          chk("release", key_release, m_rel);
          chk("long", key_long, m_long);
          chk("press_and_release", key_press & key_release, '0);
        end
      end
    join_none

    // Reset with all keys held down
    wait_neg(1);
    chk_en = 1'b1;
    key = 4'b0000;
    wait_neg(3);
    chk("rst_level", key_level, 4'b0000);
    chk("rst_press", key_press, 4'b0000);
    chk("rst_release", key_release, 4'b0000);
    chk("rst_long", key_long, 4'b0000);
    rst_n = 1'b1;
    wait_neg(18);
    chk("rst_press_early", key_press, 4'b0000);
    wait_neg(1);
    chk("rst_press_at18", key_press, 4'b1111);
    chk("model_press_at18", m_press, 4'b1111);
    wait_neg(1);
    chk("rst_press_one_cycle", key_press, 4'b0000);
    chk("rst_level_held", key_level, 4'b1111);
    key = 4'b1111;
    wait_neg(19);
    chk("all_release_at18", key_release, 4'b1111);
    wait_neg(5);

    // Single press/release on key[1]
    key[1] = 1'b0;
    wait_neg(18);
    chk("k1_press_early", key_press, 4'b0000);
    wait_neg(1);
    chk("k1_press", key_press, 4'b0010);
    chk("k1_level", key_level, 4'b0010);
    wait_neg(11);
    chk("k1_level_held", key_level, 4'b0010);
    key[1] = 1'b1;
    wait_neg(18);
    chk("k1_release_early", key_release, 4'b0000);
    wait_neg(1);
    chk("k1_release", key_release, 4'b0010);
    chk("k1_level_off", key_level, 4'b0000);
    wait_neg(3);

    // Bounce on key[2]
    cnt = 0; at = 0;
    key[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin @(negedge clk); if (key_press[2]) cnt++; end
    key[2] = 1'b1;
    for (int k = 0; k < 3; k++) begin @(negedge clk); if (key_press[2]) cnt++; end
    key[2] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (key_press[2]) begin cnt++; at = k; end
    end
    chk_int("bounce_press_count", cnt, 1);
    chk_int("bounce_press_latency", at, 18 + 1);
    key[2] = 1'b1;
    wait_neg(25);

    // Simultaneous press, then reset while pressed
    key = 4'b0110;
    wait_neg(19);
    chk("simul_press", key_press, 4'b1001);
    wait_neg(5);
    rst_n = 1'b0;
    key = 4'b1111;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (key_release != 4'b0000) cnt++;
    end
    chk_int("no_release_after_reset", cnt, 0);
    chk("level_after_reset", key_level, 4'b0000);

    // Long hold on key[0]
    key[0] = 1'b0;
    cnt = 0; at = 0; cnt2 = 0; at2 = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (key_press[0]) begin cnt++; at = k; end
      if (key_long[0]) begin cnt2++; at2 = k; end
    end
    chk_int("long_press_count", cnt, 1);
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
    chk_int("long_pulse_count", cnt2, 1);
    chk_int("long_latency", at2 - at, L);
`else
    chk_int("long_pulse_count_off", cnt2, 0);
`endif
    key = 4'b1111;
    wait_neg(25);

    // Random bouncing with occasional resets
    for (int i = 0; i < N; i++) rem[i] = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 1499) != 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          key[i] = ~key[i];
          rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : $urandom_range(10, 60);
        end else begin
          rem[i]--;
        end
      end
    end
    rst_n = 1'b1;
    key = 4'b1111;
    wait_neg(25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
